// File: rtl/divclk_sched_if.sv
// -----------------------------------------------------------------------------
// divclk_sched_if
//   Divide-value handshake between a producer (CPU register, test bench, ...)
//   and the divclk_sched clock-divider scheduler.
//
//   Signals
//     div_valid  producer -> scheduler  new divide value offered
//     div_data   producer -> scheduler  offered divide value (W bits)
//     div_ready  scheduler -> producer  scheduler can accept div_data
//
//   A transfer happens on any clock edge where div_valid & div_ready are both 1.
//   W must match the scheduler's derived width $clog2(MAXDIV+1).
// -----------------------------------------------------------------------------
interface divclk_sched_if #(
    parameter int W = 26
) ();
    logic         div_valid;
    logic [W-1:0] div_data;
    logic         div_ready;

    modport master (
        output div_valid,
        output div_data,
        input  div_ready
    );

    modport slave (
        input  div_valid,
        input  div_data,
        output div_ready
    );
endinterface : divclk_sched_if

// File: rtl/divclk_sched.sv
// -----------------------------------------------------------------------------
// divclk_sched
//   Run-time scheduler for a clock-divider counter. Counts 0..N-1 with
//   N = active_div and emits a one-cycle clock-enable tick on each wrap.
//   New divide values arrive over a valid/ready handshake and only take effect
//   at a period boundary (or when the counter is stopped), so downstream timers
//   never see a truncated period.
//
//   Parameters
//     MAXDIV  largest legal divide value
//     DEFDIV  divide value loaded at reset (1..MAXDIV)
//     W       width of divide/count values, $clog2(MAXDIV+1) (derived)
//
//   Ports
//     clk         in   system clock
//     rst         in   synchronous reset, active-high
//     run         in   level: 1 = count, 0 = stop and return to IDLE
//     oneshot     in   level: 1 = stop after the next tick
//     div         slave modport of divclk_sched_if (div_valid/div_data/div_ready)
//     tick        out  one-cycle pulse per period (registered)
//     busy        out  state != IDLE (decoded)
//     active_div  out  divide value currently in force (registered)
//     err         out  sticky: last accepted value was illegal (registered)
//     clkdiv      out  ~50% duty divided clock, only with DIVCLK_SCHED_CLKOUT_EN
//
//   Build option
//     DIVCLK_SCHED_CLKOUT_EN  adds the registered clkdiv output.
// -----------------------------------------------------------------------------
module divclk_sched #(
    parameter int   MAXDIV = 50_000_000,
    parameter int   DEFDIV = 10,
    localparam int  W      = $clog2(MAXDIV + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          oneshot,
    divclk_sched_if.slave div,
    output logic          tick,
    output logic          busy,
    output logic [W-1:0]  active_div,
    output logic          err
`ifdef DIVCLK_SCHED_CLKOUT_EN
    ,
    output logic          clkdiv
`endif
);

    // Elaboration-time sanity check on the reset divide value.
    if (DEFDIV < 1 || DEFDIV > MAXDIV) begin : g_bad_defdiv
        $error("divclk_sched: DEFDIV must be in 1..MAXDIV");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // stopped, cnt held at 0
        RUN  = 2'd1,   // counting, nothing pending
        PEND = 2'd2    // counting, one new divide value waiting for the wrap
    } state_t;

    state_t         state;
    logic [W-1:0]   cnt;
    logic [W-1:0]   pend;

    logic           accept;
    logic           legal;
    logic           wrap;

    // Handshake and status outputs decoded straight from the state register.
    assign div.div_ready = (state != PEND);
    assign busy          = (state != IDLE);

    assign accept = div.div_valid & div.div_ready;
    assign legal  = (div.div_data != '0) && (div.div_data <= W'(MAXDIV));
    // active_div is never 0, so N-1 cannot underflow.
    assign wrap   = (cnt == active_div - W'(1));

    // NOTE: all state below is updated with non-blocking assignments so every
    // branch sees the pre-edge values of cnt/state/active_div; blocking
    // assignments here would let later branches observe half-updated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            tick       <= 1'b0;
            err        <= 1'b0;
            active_div <= W'(DEFDIV);
            // NOTE: pend is reset only so the discarded value never leaks out;
            // it is always overwritten before use, so this is not functionally
            // required and could be dropped if reset fan-out matters.
            pend       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    tick <= 1'b0;
                    // While stopped, a new value goes straight into force.
                    if (accept) begin
                        if (legal) begin
                            active_div <= div.div_data;
                            err        <= 1'b0;
                        end else begin
                            err        <= 1'b1;
                        end
                    end
                    if (run) begin
                        state <= RUN;
                    end
                end

                RUN, PEND: begin
                    if (!run) begin
                        // Stop: no period is in flight any more, so a pending
                        // value and a same-edge offer both apply immediately.
                        state <= IDLE;
                        cnt   <= '0;
                        tick  <= 1'b0;
                        if (state == PEND) begin
                            active_div <= pend;
                        end
                        // accept implies RUN here (div_ready is 0 in PEND).
                        if (accept) begin
                            if (legal) begin
                                active_div <= div.div_data;
                                err        <= 1'b0;
                            end else begin
                                err        <= 1'b1;
                            end
                        end
                    end else if (wrap) begin
                        // Period boundary: tick, restart, swap in pending value.
                        cnt  <= '0;
                        tick <= 1'b1;
                        if (state == PEND) begin
                            active_div <= pend;
                        end
                        if (oneshot) begin
                            // Ending in IDLE, so a same-edge offer applies
                            // directly, exactly as it would on a stop.
                            state <= IDLE;
                            if (accept) begin
                                if (legal) begin
                                    active_div <= div.div_data;
                                    err        <= 1'b0;
                                end else begin
                                    err        <= 1'b1;
                                end
                            end
                        end else if (accept && legal) begin
                            // Offer on the wrap edge waits for the next wrap.
                            pend  <= div.div_data;
                            err   <= 1'b0;
                            state <= PEND;
                        end else begin
                            if (accept) begin
                                err <= 1'b1;
                            end
                            state <= RUN;
                        end
                    end else begin
                        cnt  <= cnt + W'(1);
                        tick <= 1'b0;
                        if (accept) begin
                            if (legal) begin
                                pend  <= div.div_data;
                                err   <= 1'b0;
                                state <= PEND;
                            end else begin
                                err   <= 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    tick  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DIVCLK_SCHED_CLKOUT_EN
    // Divided clock: low for the first N/2 counts of a period, high for the
    // rest. Uses the pre-edge cnt, so it lags the count by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            clkdiv <= 1'b0;
        end else if (busy && run) begin
            clkdiv <= (cnt >= (active_div >> 1));
        end else begin
            clkdiv <= 1'b0;
        end
    end
`endif

endmodule : divclk_sched

// File: tb/tb_divclk_sched.sv
// -----------------------------------------------------------------------------
// tb_divclk_sched
//   Directed self-checking bench for divclk_sched (MAXDIV=50_000_000,
//   DEFDIV=10). Inputs are driven and outputs sampled on the falling edge;
//   "cycle c" below means the falling edge after the c-th rising edge counted
//   from the edge that first samples run=1.
// -----------------------------------------------------------------------------
module tb_divclk_sched;

    localparam int MAXDIV = 50_000_000;
    localparam int DEFDIV = 10;
    localparam int W      = $clog2(MAXDIV + 1);

    logic         clk = 1'b0;
    logic         rst;
    logic         run;
    logic         oneshot;
    logic         tick;
    logic         busy;
    logic [W-1:0] active_div;
    logic         err;
`ifdef DIVCLK_SCHED_CLKOUT_EN
    logic         clkdiv;
`endif

    int n_vec = 0;
    int n_err = 0;

    divclk_sched_if #(.W(W)) div_if ();

    divclk_sched #(
        .MAXDIV (MAXDIV),
        .DEFDIV (DEFDIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .oneshot    (oneshot),
        .div        (div_if),
        .tick       (tick),
        .busy       (busy),
        .active_div (active_div),
        .err        (err)
`ifdef DIVCLK_SCHED_CLKOUT_EN
        ,
        .clkdiv     (clkdiv)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance exactly one rising edge and land on the following falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    // Offer one value while stopped (IDLE applies it on the next edge).
    task automatic offer_idle(input logic [W-1:0] val);
        div_if.div_valid = 1'b1;
        div_if.div_data  = val;
        cyc();
        div_if.div_valid = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        run              = 1'b0;
        oneshot          = 1'b0;
        div_if.div_valid = 1'b0;
        div_if.div_data  = '0;
        cyc();
        cyc();

        // ---------------- reset values ----------------
        check("rst_tick",   tick,             0);
        check("rst_busy",   busy,             0);
        check("rst_err",    err,              0);
        check("rst_ready",  div_if.div_ready, 1);
        check("rst_active", active_div,       DEFDIV);

        // ---------------- 1: default N=10, ticks at cycles 11/21/31 ----------
        rst = 1'b0;
        run = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            cyc();
            check($sformatf("t1_tick_c%0d", c), tick, (c == 11 || c == 21 || c == 31) ? 1 : 0);
            if (c == 1) begin
                check("t1_busy",   busy,       1);
                check("t1_active", active_div, 10);
            end
        end

        // ---------------- 2: switch 10 -> 4 at cnt=3 ----------------
        // After cycle 31 cnt=0; after cycle 34 cnt=3; accept on edge 35.
        for (int c = 32; c <= 34; c++) begin
            cyc();
            check("t2_pre_tick", tick, 0);
        end
        div_if.div_valid = 1'b1;
        div_if.div_data  = W'(4);
        cyc();                              // cycle 35: accepted, PEND
        div_if.div_valid = 1'b0;
        check("t2_ready_pend",  div_if.div_ready, 0);
        check("t2_active_pend", active_div,       10);
        // Wrap of the N=10 period on edge 41, then every 4 edges.
        for (int c = 36; c <= 53; c++) begin
            cyc();
            check($sformatf("t2_tick_c%0d", c), tick,
                  (c == 41 || c == 45 || c == 49 || c == 53) ? 1 : 0);
            check($sformatf("t2_ready_c%0d", c), div_if.div_ready, (c >= 41) ? 1 : 0);
            check($sformatf("t2_active_c%0d", c), active_div, (c >= 41) ? 4 : 10);
        end
        run = 1'b0;
        cyc();
        check("t2_stop_busy", busy, 0);
        check("t2_stop_tick", tick, 0);

        // ---------------- 3: illegal values in IDLE ----------------
        offer_idle(W'(0));
        check("t3_zero_err",    err,        1);
        check("t3_zero_active", active_div, 4);
        check("t3_zero_ready",  div_if.div_ready, 1);
        offer_idle(W'(5));
        check("t3_five_err",    err,        0);
        check("t3_five_active", active_div, 5);
        offer_idle(W'(MAXDIV + 1));
        check("t3_over_err",    err,        1);
        check("t3_over_active", active_div, 5);
        offer_idle(W'(MAXDIV));
        check("t3_max_err",     err,        0);
        check("t3_max_active",  active_div, MAXDIV);

        // ---------------- 4: one-shot with N=3 ----------------
        offer_idle(W'(3));
        oneshot = 1'b1;
        run     = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            check($sformatf("t4_busy_c%0d", c), busy, 1);
            check($sformatf("t4_tick_c%0d", c), tick, 0);
        end
        cyc();                              // cycle 4: the single tick
        check("t4_tick",      tick, 1);
        check("t4_busy_tick", busy, 0);
        run = 1'b0;
        for (int c = 5; c <= 10; c++) begin
            cyc();
            check($sformatf("t4_after_tick_c%0d", c), tick, 0);
            check($sformatf("t4_after_busy_c%0d", c), busy, 0);
        end
        oneshot = 1'b0;

        // ---------------- stop with a pending value ----------------
        offer_idle(W'(5));
        run = 1'b1;
        cyc();                              // RUN, cnt=0
        div_if.div_valid = 1'b1;
        div_if.div_data  = W'(7);
        cyc();                              // accepted -> PEND
        div_if.div_valid = 1'b0;
        check("stp_ready_pend",  div_if.div_ready, 0);
        check("stp_active_pend", active_div,       5);
        run = 1'b0;
        cyc();
        check("stp_busy",   busy,             0);
        check("stp_active", active_div,       7);
        check("stp_ready",  div_if.div_ready, 1);

        // ---------------- accept on the same edge as stop ----------------
        run = 1'b1;
        cyc();
        cyc();
        run              = 1'b0;
        div_if.div_valid = 1'b1;
        div_if.div_data  = W'(6);
        cyc();
        div_if.div_valid = 1'b0;
        check("sacc_busy",   busy,       0);
        check("sacc_active", active_div, 6);

        // ---------------- illegal offer while running ----------------
        run = 1'b1;
        cyc();
        div_if.div_valid = 1'b1;
        div_if.div_data  = W'(0);
        cyc();
        check("rill_err",    err,              1);
        check("rill_ready",  div_if.div_ready, 1);
        check("rill_active", active_div,       6);

        // ---------------- 5: reset while PEND with 7 pending ----------------
        div_if.div_data = W'(7);
        cyc();
        div_if.div_valid = 1'b0;
        check("t5_ready_pend", div_if.div_ready, 0);
        check("t5_err_clear",  err,              0);
        rst = 1'b1;
        cyc();
        check("t5_tick",   tick,             0);
        check("t5_busy",   busy,             0);
        check("t5_err",    err,              0);
        check("t5_ready",  div_if.div_ready, 1);
        check("t5_active", active_div,       DEFDIV);
        run = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        check("t5_hold_active", active_div, DEFDIV);

        // ---------------- 6: N=1 gives a constant tick ----------------
        offer_idle(W'(1));
        check("t6_active", active_div, 1);
        run = 1'b1;
        cyc();
        check("t6_tick_c1", tick, 0);
        for (int c = 2; c <= 6; c++) begin
            cyc();
            check($sformatf("t6_tick_c%0d", c), tick, 1);
        end
        run = 1'b0;
        cyc();
        check("t6_stop_tick", tick, 0);

        // ---------------- N=4: ticks and optional clkdiv ----------------
        offer_idle(W'(4));
        run = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            cyc();
            check($sformatf("n4_tick_c%0d", c), tick, (c == 5 || c == 9 || c == 13) ? 1 : 0);
`ifdef DIVCLK_SCHED_CLKOUT_EN
            // Pattern 0,0,1,1 starts at cycle 2 (first edge with cnt=0 pre-edge).
            check($sformatf("n4_clkdiv_c%0d", c), clkdiv,
                  (c >= 2 && ((c - 2) % 4) >= 2) ? 1 : 0);
`endif
        end
        run = 1'b0;
        cyc();
        check("n4_stop_busy", busy, 0);
`ifdef DIVCLK_SCHED_CLKOUT_EN
        check("n4_stop_clkdiv", clkdiv, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_divclk_sched
